// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with a valid/ready handshake and a two-entry skid buffer.
// The upstream ready is a register, so a downstream stall never ripples combinationally to earlier stages.
module pipe_stage_skid_reg #(
    parameter int              PAYLOAD_W   = 69,
    parameter int              EXC_W       = 5,
    parameter int              PC_W        = 32,
    parameter logic [PC_W-1:0] HANDLER_PC  = 32'h0000_4180,
    parameter logic [PC_W-1:0] RESET_PC    = 32'h0000_0000,
    parameter bit              KILL_ON_EXC = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 req_i,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [PC_W-1:0]      in_pc_i,
    input  logic [31:0]          in_instr_i,
    input  logic [PAYLOAD_W-1:0] in_payload_i,
    input  logic [EXC_W-1:0]     in_exc_i,
    input  logic                 in_bd_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [PC_W-1:0]      out_pc_o,
    output logic [31:0]          out_instr_o,
    output logic [PAYLOAD_W-1:0] out_payload_o,
    output logic [EXC_W-1:0]     out_exc_o,
    output logic                 out_bd_o,
    output logic [1:0]           occupancy_o,
    output logic [1:0]           state_o
);

    // Handshake: a transfer happens on an edge where valid and ready are both high.
    // in_ready_o depends only on held state; out_valid_o/out_* stay stable while out_ready_i is low.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                 in_ready_q;
    logic                 out_valid_q;
    logic [1:0]           occupancy_q;

    logic [PC_W-1:0]      m_pc_q;
    logic [31:0]          m_instr_q;
    logic [PAYLOAD_W-1:0] m_payload_q;
    logic [EXC_W-1:0]     m_exc_q;
    logic                 m_bd_q;

    logic [PC_W-1:0]      s_pc_q;
    logic [31:0]          s_instr_q;
    logic [PAYLOAD_W-1:0] s_payload_q;
    logic [EXC_W-1:0]     s_exc_q;
    logic                 s_bd_q;

    logic                 acc;
    logic                 con;
    logic [31:0]          in_instr_d;

    assign acc = in_valid_i & in_ready_q;
    assign con = out_valid_q & out_ready_i;

    // An instruction that already carries an exception must not execute further down the pipe.
    assign in_instr_d = (KILL_ON_EXC && (in_exc_i != '0)) ? 32'd0 : in_instr_i;

    always_comb begin
        state_d = state_q;
        if (req_i || flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) state_d = ST_BUSY;
                end
                ST_BUSY: begin
                    if (acc && !con)      state_d = ST_FULL;
                    else if (!acc && con) state_d = ST_EMPTY;
                end
                ST_FULL: begin
                    if (con) state_d = ST_BUSY;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occupancy_q <= 2'd0;
            m_pc_q      <= RESET_PC;
            m_instr_q   <= '0;
            m_payload_q <= '0;
            m_exc_q     <= '0;
            m_bd_q      <= 1'b0;
            s_pc_q      <= '0;
            s_instr_q   <= '0;
            s_payload_q <= '0;
            s_exc_q     <= '0;
            s_bd_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != ST_FULL);
            out_valid_q <= (state_d != ST_EMPTY);
            occupancy_q <= (state_d == ST_FULL) ? 2'd2 :
                           (state_d == ST_BUSY) ? 2'd1 : 2'd0;

            if (req_i) begin
                // Handler bubble keeps the delay-slot flag so EPC logic can use it.
                m_pc_q      <= HANDLER_PC;
                m_instr_q   <= '0;
                m_payload_q <= '0;
                m_exc_q     <= '0;
                m_bd_q      <= in_bd_i;
            end else if (flush_i) begin
                m_pc_q      <= RESET_PC;
                m_instr_q   <= '0;
                m_payload_q <= '0;
                m_exc_q     <= '0;
                m_bd_q      <= 1'b0;
            end else begin
                case (state_q)
                    ST_EMPTY: begin
                        if (acc) begin
                            m_pc_q      <= in_pc_i;
                            m_instr_q   <= in_instr_d;
                            m_payload_q <= in_payload_i;
                            m_exc_q     <= in_exc_i;
                            m_bd_q      <= in_bd_i;
                        end
                    end
                    ST_BUSY: begin
                        if (acc && con) begin
                            m_pc_q      <= in_pc_i;
                            m_instr_q   <= in_instr_d;
                            m_payload_q <= in_payload_i;
                            m_exc_q     <= in_exc_i;
                            m_bd_q      <= in_bd_i;
                        end else if (acc) begin
                            s_pc_q      <= in_pc_i;
                            s_instr_q   <= in_instr_d;
                            s_payload_q <= in_payload_i;
                            s_exc_q     <= in_exc_i;
                            s_bd_q      <= in_bd_i;
                        end
                    end
                    ST_FULL: begin
                        if (con) begin
                            m_pc_q      <= s_pc_q;
                            m_instr_q   <= s_instr_q;
                            m_payload_q <= s_payload_q;
                            m_exc_q     <= s_exc_q;
                            m_bd_q      <= s_bd_q;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready_o    = in_ready_q;
    assign out_valid_o   = out_valid_q;
    assign occupancy_o   = occupancy_q;
    assign state_o       = state_q;
    assign out_pc_o      = m_pc_q;
    assign out_instr_o   = m_instr_q;
    assign out_payload_o = m_payload_q;
    assign out_exc_o     = m_exc_q;
    assign out_bd_o      = m_bd_q;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed bench for pipe_stage_skid_reg: reset, streaming, stall/release ordering,
// exception kill, req bubble and req/flush/reset priority.
module tb_pipe_stage_skid_reg;

    localparam int PAYLOAD_W = 69;
    localparam int EXC_W     = 5;
    localparam int PC_W      = 32;

    logic                 clk_i;
    logic                 reset_i;
    logic                 req_i;
    logic                 flush_i;
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [PC_W-1:0]      in_pc_i;
    logic [31:0]          in_instr_i;
    logic [PAYLOAD_W-1:0] in_payload_i;
    logic [EXC_W-1:0]     in_exc_i;
    logic                 in_bd_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [PC_W-1:0]      out_pc_o;
    logic [31:0]          out_instr_o;
    logic [PAYLOAD_W-1:0] out_payload_o;
    logic [EXC_W-1:0]     out_exc_o;
    logic                 out_bd_o;
    logic [1:0]           occupancy_o;
    logic [1:0]           state_o;

    int checks_cnt;
    int errors_cnt;
    logic [PC_W-1:0] exp_q[$];

    pipe_stage_skid_reg dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .req_i        (req_i),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_pc_i      (in_pc_i),
        .in_instr_i   (in_instr_i),
        .in_payload_i (in_payload_i),
        .in_exc_i     (in_exc_i),
        .in_bd_i      (in_bd_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_pc_o     (out_pc_o),
        .out_instr_o  (out_instr_o),
        .out_payload_o(out_payload_o),
        .out_exc_o    (out_exc_o),
        .out_bd_o     (out_bd_o),
        .occupancy_o  (occupancy_o),
        .state_o      (state_o)
    );

    // Clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_in(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                            input logic [4:0] exc, input logic bd);
        in_valid_i   = v;
        in_pc_i      = pc;
        in_instr_i   = instr;
        in_payload_i = {37'd0, pc};
        in_exc_i     = exc;
        in_bd_i      = bd;
    endtask

    task automatic idle_in();
        drive_in(1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    endtask

    initial begin
        checks_cnt  = 0;
        errors_cnt  = 0;
        reset_i     = 1'b0;
        req_i       = 1'b0;
        flush_i     = 1'b0;
        out_ready_i = 1'b0;
        idle_in();

        // 1: reset
        tick();
        tick();
        check("rst_valid", out_valid_o, 0);
        check("rst_pc", out_pc_o, 0);
        check("rst_occ", occupancy_o, 0);
        reset_i = 1'b1;
        tick();
        check("rst_ready", in_ready_o, 1);
        check("rst_state", state_o, 0);

        // 2: streaming with out_ready high, one cycle latency
        out_ready_i = 1'b1;
        drive_in(1'b1, 32'h3000, 32'h2401_0001, 5'd0, 1'b0);
        tick();
        check("s_pc0", out_pc_o, 32'h3000);
        check("s_vld0", out_valid_o, 1);
        check("s_occ0", occupancy_o, 1);
        check("s_instr0", out_instr_o, 32'h2401_0001);
        drive_in(1'b1, 32'h3004, 32'h2401_0002, 5'd0, 1'b1);
        tick();
        check("s_pc1", out_pc_o, 32'h3004);
        check("s_bd1", out_bd_o, 1);
        check("s_occ1", occupancy_o, 1);
        drive_in(1'b1, 32'h3008, 32'h2401_0003, 5'd0, 1'b0);
        tick();
        check("s_pc2", out_pc_o, 32'h3008);
        check("s_pay2", out_payload_o, 69'h3008);
        check("s_rdy2", in_ready_o, 1);
        idle_in();
        tick();
        check("s_drain_vld", out_valid_o, 0);
        check("s_drain_occ", occupancy_o, 0);

        // 3: stall fills skid, release yields the exact order
        out_ready_i = 1'b0;
        drive_in(1'b1, 32'h3000, 32'h0000_0010, 5'd0, 1'b0);
        tick();
        check("st_occ1", occupancy_o, 1);
        drive_in(1'b1, 32'h3004, 32'h0000_0011, 5'd0, 1'b0);
        tick();
        check("st_occ2", occupancy_o, 2);
        check("st_rdy0", in_ready_o, 0);
        check("st_state", state_o, 2);
        drive_in(1'b1, 32'h3008, 32'h0000_0012, 5'd0, 1'b0);
        tick();
        check("st_hold_pc", out_pc_o, 32'h3000);
        check("st_hold_occ", occupancy_o, 2);
        exp_q.push_back(32'h3000);
        exp_q.push_back(32'h3004);
        exp_q.push_back(32'h3008);
        out_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic accepted;
            accepted = in_valid_i && in_ready_o;
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) check("st_dup", out_pc_o, 32'hFFFF_FFFF);
                else check("st_order", out_pc_o, exp_q.pop_front());
            end
            tick();
            if (accepted) idle_in();
        end
        check("st_left", exp_q.size(), 0);
        check("st_end_occ", occupancy_o, 0);

        // 4: exception kills the instruction word
        drive_in(1'b1, 32'h3010, 32'h8C01_0000, 5'd4, 1'b0);
        tick();
        check("ex_instr", out_instr_o, 0);
        check("ex_exc", out_exc_o, 4);
        check("ex_pc", out_pc_o, 32'h3010);
        idle_in();
        tick();

        // 5: req from FULL inserts handler bubble
        out_ready_i = 1'b0;
        drive_in(1'b1, 32'h3020, 32'h1, 5'd0, 1'b0);
        tick();
        drive_in(1'b1, 32'h3024, 32'h2, 5'd0, 1'b0);
        tick();
        check("rq_full", occupancy_o, 2);
        req_i = 1'b1;
        drive_in(1'b1, 32'h3028, 32'h3, 5'd0, 1'b1);
        tick();
        req_i = 1'b0;
        idle_in();
        check("rq_vld", out_valid_o, 0);
        check("rq_pc", out_pc_o, 32'h4180);
        check("rq_bd", out_bd_o, 1);
        check("rq_occ", occupancy_o, 0);
        check("rq_instr", out_instr_o, 0);
        check("rq_rdy", in_ready_o, 1);

        // 6: req beats flush, flush alone, reset beats req
        drive_in(1'b1, 32'h3030, 32'h4, 5'd0, 1'b0);
        tick();
        req_i   = 1'b1;
        flush_i = 1'b1;
        idle_in();
        tick();
        req_i   = 1'b0;
        flush_i = 1'b0;
        check("rf_pc", out_pc_o, 32'h4180);
        check("rf_occ", occupancy_o, 0);
        drive_in(1'b1, 32'h3034, 32'h5, 5'd0, 1'b1);
        tick();
        check("fl_pre_pc", out_pc_o, 32'h3034);
        flush_i = 1'b1;
        drive_in(1'b1, 32'h3038, 32'h6, 5'd0, 1'b1);
        tick();
        flush_i = 1'b0;
        idle_in();
        check("fl_pc", out_pc_o, 0);
        check("fl_occ", occupancy_o, 0);
        check("fl_vld", out_valid_o, 0);
        check("fl_bd", out_bd_o, 0);
        reset_i = 1'b0;
        req_i   = 1'b1;
        in_bd_i = 1'b1;
        tick();
        reset_i = 1'b1;
        req_i   = 1'b0;
        idle_in();
        check("rr_pc", out_pc_o, 0);
        check("rr_bd", out_bd_o, 0);
        check("rr_occ", occupancy_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
